// File: rtl/ddc_retune_ctrl.sv
// Retune sequencer for a multi-channel DDC: holds the datapath in reset, loads the
// phase table, blanks the output while the CIC flushes, then accepts retune requests.
module ddc_retune_ctrl #(
   parameter int NUM_CHANS     = 13,
   parameter int PHASE_WIDTH   = 32,
   parameter int RSTN_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 256
) (
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic [PHASE_WIDTH-1:0]               s_axis_tdata,
   input  logic [7:0]                           s_axis_tuser,
   input  logic                                 soft_rst,
   output logic [(NUM_CHANS+1)*PHASE_WIDTH-1:0] cfg,
   output logic                                 busy,
   output logic                                 err_chan,
   output logic [15:0]                          retune_cnt
);

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      LOAD       = 2'd1,
      SETTLE     = 2'd2,
      IDLE       = 2'd3
   } state_t;

   localparam logic [15:0] RSTN_LAST   = 16'(RSTN_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_t                           state_r;
   logic [15:0]                      cnt_r;
   logic                             retune_pend_r;
   logic [PHASE_WIDTH-1:0]           ctrl_r;
   logic [NUM_CHANS*PHASE_WIDTH-1:0] table_r;
   logic                             chan_ok_s;

   // Control word 0 layout: bit0 rstn, bit8 blank, bit16 phasevld
   function automatic logic [PHASE_WIDTH-1:0] ctrl_word(input logic rstn,
                                                        input logic blank,
                                                        input logic phasevld);
      logic [PHASE_WIDTH-1:0] w;
      w     = '0;
      w[0]  = rstn;
      w[8]  = blank;
      w[16] = phasevld;
      return w;
   endfunction

   assign chan_ok_s     = ({1'b0, s_axis_tuser} < 9'(NUM_CHANS));
   assign s_axis_tready = (state_r == IDLE) && !soft_rst && !areset;
   assign cfg           = {table_r, ctrl_r};

   // Sequencer state, phase table and all registered outputs
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r       <= RESET_HOLD;
         cnt_r         <= 16'd0;
         retune_pend_r <= 1'b0;
         table_r       <= '0;
         ctrl_r        <= ctrl_word(1'b0, 1'b1, 1'b0);
         busy          <= 1'b1;
         err_chan      <= 1'b0;
         retune_cnt    <= 16'd0;
      end else begin
         err_chan <= 1'b0;
         case (state_r)
            RESET_HOLD: begin
               if (cnt_r == RSTN_LAST) begin
                  state_r <= LOAD;
                  cnt_r   <= 16'd0;
                  ctrl_r  <= ctrl_word(1'b1, 1'b1, 1'b1);
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            LOAD: begin
               state_r <= SETTLE;
               cnt_r   <= 16'd0;
               ctrl_r  <= ctrl_word(1'b1, 1'b1, 1'b0);
            end
            SETTLE: begin
               if (cnt_r == SETTLE_LAST) begin
                  state_r       <= IDLE;
                  cnt_r         <= 16'd0;
                  ctrl_r        <= ctrl_word(1'b1, 1'b0, 1'b0);
                  busy          <= 1'b0;
                  retune_pend_r <= 1'b0;
                  // Only request-driven loads count; reset sequences leave the counter alone
                  if (retune_pend_r) begin
                     retune_cnt <= retune_cnt + 16'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            IDLE: begin
               if (soft_rst) begin
                  state_r       <= RESET_HOLD;
                  cnt_r         <= 16'd0;
                  ctrl_r        <= ctrl_word(1'b0, 1'b1, 1'b0);
                  busy          <= 1'b1;
                  retune_pend_r <= 1'b0;
               end else if (s_axis_tvalid) begin
                  if (chan_ok_s) begin
                     for (int j = 0; j < NUM_CHANS; j++) begin
                        if (s_axis_tuser == 8'(j)) begin
                           table_r[PHASE_WIDTH*j +: PHASE_WIDTH] <= s_axis_tdata;
                        end
                     end
                     state_r       <= LOAD;
                     cnt_r         <= 16'd0;
                     ctrl_r        <= ctrl_word(1'b1, 1'b1, 1'b1);
                     busy          <= 1'b1;
                     retune_pend_r <= 1'b1;
                  end else begin
                     err_chan <= 1'b1;
                  end
               end
            end
            default: begin
               state_r       <= RESET_HOLD;
               cnt_r         <= 16'd0;
               ctrl_r        <= ctrl_word(1'b0, 1'b1, 1'b0);
               busy          <= 1'b1;
               retune_pend_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
